// File: rtl/alu64_seq_if.sv
// Request/response handshake bundle for the 64-bit ALU sequencer.
interface alu64_seq_if;
  localparam int unsigned DW  = 64;
  localparam int unsigned OPW = 3;

  logic           req_valid;
  logic           req_ready;
  logic [OPW-1:0] req_op;
  logic [DW-1:0]  req_a;
  logic [DW-1:0]  req_b;

  logic           rsp_valid;
  logic           rsp_ready;
  logic [DW-1:0]  rsp_result;
  logic           rsp_cout;
  logic           rsp_overflow;
  logic           rsp_zero;

  // Requester side: issues operations, consumes responses
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_cout, rsp_overflow, rsp_zero
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_overflow, rsp_zero
  );
endinterface

// File: rtl/alu64_seq.sv
// 64-bit operation sequencer driving a 32-bit combinational ALU in two passes
// (low word, then high word with the low carry chained into Cin).
module alu64_seq (
  input  logic        clk,
  input  logic        rst_n,
  alu64_seq_if.slave  bus,
  output logic [2:0]  o_alu_mode,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic        o_alu_cin,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_cout,
  input  logic        i_alu_overflow,
  input  logic        i_alu_zero
);

  localparam int unsigned DW  = 64;
  localparam int unsigned WW  = 32;
  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] OP_ADD   = 3'b000;
  localparam logic [OPW-1:0] OP_SUB   = 3'b001;
  localparam logic [OPW-1:0] OP_NOT   = 3'b010;
  localparam logic [OPW-1:0] OP_AND   = 3'b011;
  localparam logic [OPW-1:0] OP_OR    = 3'b100;
  localparam logic [OPW-1:0] OP_XOR   = 3'b101;
  localparam logic [OPW-1:0] MODE_ADD = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  // Latched operation
  logic [OPW-1:0]  r_op;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;

  // Low-word capture
  logic [WW-1:0]   r_res_lo;
  logic            r_z_lo;

  // Registered outputs
  logic            r_req_ready;
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_result;
  logic            r_rsp_cout;
  logic            r_rsp_ovf;
  logic            r_rsp_zero;
  logic [OPW-1:0]  r_alu_mode;
  logic [WW-1:0]   r_alu_a;
  logic [WW-1:0]   r_alu_b;
  logic            r_alu_cin;

  // Word-drive selection for the state being entered
  logic            w_accept;
  logic            w_drv_en;
  logic            w_drv_hi;
  logic [OPW-1:0]  w_drv_op;
  logic [WW-1:0]   w_drv_a;
  logic [WW-1:0]   w_drv_b;

  // Next ALU drive values
  logic [OPW-1:0]  w_alu_mode_nxt;
  logic [WW-1:0]   w_alu_a_nxt;
  logic [WW-1:0]   w_alu_b_nxt;
  logic            w_alu_cin_nxt;

  logic            w_op_arith;
  logic            w_op_rsvd;

  assign w_op_arith = (r_op == OP_ADD) || (r_op == OP_SUB);
  assign w_op_rsvd  = r_op[2] & r_op[1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and selection of the word the ALU works on next cycle
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_drv_en    = 1'b0;
    w_drv_hi    = 1'b0;
    w_drv_op    = '0;
    w_drv_a     = '0;
    w_drv_b     = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_state_nxt = S_LO;
          w_accept    = 1'b1;
          w_drv_en    = 1'b1;
          w_drv_op    = bus.req_op;
          w_drv_a     = bus.req_a[WW-1:0];
          w_drv_b     = bus.req_b[WW-1:0];
        end
      end
      S_LO: begin
        w_state_nxt = S_HI;
        w_drv_en    = 1'b1;
        w_drv_hi    = 1'b1;
        w_drv_op    = r_op;
        w_drv_a     = r_a[DW-1:WW];
        w_drv_b     = r_b[DW-1:WW];
      end
      S_HI: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Per-op ALU drive; SUB is done as A + ~B + 1 so the carry stays visible.
  // In LO the ALU carry being produced is the low-word carry chained into HI.
  always_comb begin
    w_alu_mode_nxt = '0;
    w_alu_a_nxt    = '0;
    w_alu_b_nxt    = '0;
    w_alu_cin_nxt  = 1'b0;
    if (w_drv_en) begin
      case (w_drv_op)
        OP_ADD: begin
          w_alu_mode_nxt = MODE_ADD;
          w_alu_a_nxt    = w_drv_a;
          w_alu_b_nxt    = w_drv_b;
          w_alu_cin_nxt  = w_drv_hi ? i_alu_cout : 1'b0;
        end
        OP_SUB: begin
          w_alu_mode_nxt = MODE_ADD;
          w_alu_a_nxt    = w_drv_a;
          w_alu_b_nxt    = ~w_drv_b;
          w_alu_cin_nxt  = w_drv_hi ? i_alu_cout : 1'b1;
        end
        OP_NOT, OP_AND, OP_OR, OP_XOR: begin
          w_alu_mode_nxt = w_drv_op;
          w_alu_a_nxt    = w_drv_a;
          w_alu_b_nxt    = w_drv_b;
        end
        default: begin
          w_alu_mode_nxt = MODE_ADD;
        end
      endcase
    end
  end

  // Operand latch on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_accept) begin
      r_op <= bus.req_op;
      r_a  <= bus.req_a;
      r_b  <= bus.req_b;
    end
  end

  // Low-word result capture at the edge ending LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_lo <= '0;
      r_z_lo   <= 1'b0;
    end else if (r_state == S_LO) begin
      r_res_lo <= i_alu_result;
      r_z_lo   <= i_alu_zero;
    end
  end

  // ALU drive registers, loaded for the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_mode <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_cin  <= 1'b0;
    end else begin
      r_alu_mode <= w_alu_mode_nxt;
      r_alu_a    <= w_alu_a_nxt;
      r_alu_b    <= w_alu_b_nxt;
      r_alu_cin  <= w_alu_cin_nxt;
    end
  end

  // Handshake flags and response assembly at the edge ending HI
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_cout   <= 1'b0;
      r_rsp_ovf    <= 1'b0;
      r_rsp_zero   <= 1'b0;
    end else begin
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_DONE);
      if (r_state == S_HI) begin
        r_rsp_result <= w_op_rsvd ? '0 : {i_alu_result, r_res_lo};
        r_rsp_cout   <= w_op_arith & i_alu_cout;
        r_rsp_ovf    <= w_op_arith & i_alu_overflow;
        r_rsp_zero   <= w_op_rsvd | (r_z_lo & i_alu_zero);
      end
    end
  end

  assign bus.req_ready    = r_req_ready;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_result   = r_rsp_result;
  assign bus.rsp_cout     = r_rsp_cout;
  assign bus.rsp_overflow = r_rsp_ovf;
  assign bus.rsp_zero     = r_rsp_zero;

  assign o_alu_mode = r_alu_mode;
  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_cin  = r_alu_cin;

endmodule

// File: tb/tb_alu64_seq.sv
// Scoreboard bench for alu64_seq with a behavioural 32-bit ALU attached.
module tb_alu64_seq;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;

  typedef struct packed {
    logic [63:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  logic [2:0]  alu_mode;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        alu_cin, alu_cout, alu_ovf, alu_zero;
  logic [32:0] alu_sum;

  // Observed ALU drive during LO / HI of the last operation
  logic [2:0]  lo_mode, hi_mode;
  logic [31:0] lo_a, lo_b, hi_a, hi_b;
  logic        lo_cin, hi_cin;
  int          lat;
  int          acc_wait;

  always #5 clk = ~clk;

  alu64_seq_if bus();

  alu64_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .o_alu_mode     (alu_mode),
    .o_alu_a        (alu_a),
    .o_alu_b        (alu_b),
    .o_alu_cin      (alu_cin),
    .i_alu_result   (alu_res),
    .i_alu_cout     (alu_cout),
    .i_alu_overflow (alu_ovf),
    .i_alu_zero     (alu_zero)
  );

  // Combinational 32-bit ALU
  always_comb begin
    alu_sum  = '0;
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (alu_mode)
      3'b000: begin
        alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + 33'(alu_cin);
        alu_res  = alu_sum[31:0];
        alu_cout = alu_sum[32];
        alu_ovf  = (alu_a[31] == alu_b[31]) && (alu_res[31] != alu_a[31]);
      end
      3'b001:  alu_res = alu_a - alu_b;
      3'b010:  alu_res = ~alu_a;
      3'b011:  alu_res = alu_a & alu_b;
      3'b100:  alu_res = alu_a | alu_b;
      3'b101:  alu_res = alu_a ^ alu_b;
      default: alu_res = '0;
    endcase
    alu_zero = (alu_res == 32'd0);
  end

  function automatic exp_t model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    logic [64:0] s;
    e = '0;
    s = '0;
    case (op)
      OP_ADD: begin
        s      = {1'b0, a} + {1'b0, b};
        e.res  = s[63:0];
        e.cout = s[64];
        e.ovf  = (a[63] == b[63]) && (s[63] != a[63]);
      end
      OP_SUB: begin
        s      = {1'b0, a} + {1'b0, ~b} + 65'd1;
        e.res  = s[63:0];
        e.cout = s[64];
        e.ovf  = (a[63] != b[63]) && (s[63] != a[63]);
      end
      OP_NOT:  e.res = ~a;
      OP_AND:  e.res = a & b;
      OP_OR:   e.res = a | b;
      OP_XOR:  e.res = a ^ b;
      default: e.res = '0;
    endcase
    e.zero = (e.res == 64'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op (called at a negedge), stall the response, then handshake.
  // With nq set, the next request is presented in the same cycle as rsp_ready.
  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int stall, input logic nq, input logic [2:0] nop,
                        input logic [63:0] na, input logic [63:0] nb);
    int w;
    int k;
    exp_t e;
    logic [63:0] s_res;
    logic [2:0] s_flg;
    e = '0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    w = 0;
    while (!bus.req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    acc_wait = w;
    if (!bus.req_ready) begin
      chk("accept_timeout", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb_q.push_back(model(op, a, b));
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        lo_mode = alu_mode; lo_a = alu_a; lo_b = alu_b; lo_cin = alu_cin;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_AND;
        bus.req_a     = ~a;
        bus.req_b     = ~b;
      end
      if (k == 2) begin
        hi_mode = alu_mode; hi_a = alu_a; hi_b = alu_b; hi_cin = alu_cin;
      end
    end while (!bus.rsp_valid && k < 8);
    lat = k;
    if (!bus.rsp_valid) begin
      chk("rsp_timeout", 64'(bus.rsp_valid), 64'd1);
      return;
    end
    s_res = bus.rsp_result;
    s_flg = {bus.rsp_cout, bus.rsp_overflow, bus.rsp_zero};
    repeat (stall) begin
      @(negedge clk);
      chk("hold_res", bus.rsp_result, s_res);
      chk("hold_flags", 64'({bus.rsp_cout, bus.rsp_overflow, bus.rsp_zero}), 64'(s_flg));
      chk("hold_vld", 64'(bus.rsp_valid), 64'd1);
      chk("hold_rdy", 64'(bus.req_ready), 64'd0);
    end
    if (sb_q.size() == 0) begin
      chk("sb_empty", 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      chk("result", bus.rsp_result, e.res);
      chk("cout", 64'(bus.rsp_cout), 64'(e.cout));
      chk("ovf", 64'(bus.rsp_overflow), 64'(e.ovf));
      chk("zero", 64'(bus.rsp_zero), 64'(e.zero));
    end
    bus.rsp_ready = 1'b1;
    if (nq) begin
      bus.req_valid = 1'b1;
      bus.req_op    = nop;
      bus.req_a     = na;
      bus.req_b     = nb;
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("vld_drop", 64'(bus.rsp_valid), 64'd0);
    chk("rdy_back", 64'(bus.req_ready), 64'd1);
    chk("res_kept", bus.rsp_result, e.res);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_result"}, bus.rsp_result, 64'd0);
    chk({tag, "_flags"}, 64'({bus.rsp_cout, bus.rsp_overflow, bus.rsp_zero}), 64'd0);
    chk({tag, "_alu"}, 64'({alu_mode, alu_a, alu_cin}), 64'd0);
    chk({tag, "_alu_b"}, 64'(alu_b), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra, rb;
    logic [2:0]  rop;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst");

    // ADD with carry across the word boundary
    run_op(OP_ADD, 64'h00000000_FFFFFFFF, 64'd1, 0, 1'b0, '0, '0, '0);
    chk("add_lat", 64'(lat), 64'd3);
    chk("add_lo_cin", 64'(lo_cin), 64'd0);
    chk("add_hi_cin", 64'(hi_cin), 64'd1);
    chk("add_lo_a", 64'(lo_a), 64'hFFFFFFFF);
    chk("add_hi_a", 64'(hi_a), 64'd0);

    // SUB 0-1: inverted B words, mode ADD, LO cin=1
    run_op(OP_SUB, 64'd0, 64'd1, 0, 1'b0, '0, '0, '0);
    chk("sub_lo_mode", 64'(lo_mode), 64'd0);
    chk("sub_hi_mode", 64'(hi_mode), 64'd0);
    chk("sub_lo_b", 64'(lo_b), 64'hFFFFFFFE);
    chk("sub_hi_b", 64'(hi_b), 64'hFFFFFFFF);
    chk("sub_lo_cin", 64'(lo_cin), 64'd1);
    chk("sub_hi_cin", 64'(hi_cin), 64'd0);

    run_op(OP_SUB, 64'd5, 64'd5, 0, 1'b0, '0, '0, '0);
    chk("sub55_hi_cin", 64'(hi_cin), 64'd1);
    run_op(OP_ADD, 64'h7FFFFFFF_FFFFFFFF, 64'd1, 0, 1'b0, '0, '0, '0);
    run_op(OP_SUB, 64'h80000000_00000000, 64'd1, 0, 1'b0, '0, '0, '0);

    // Logic ops and reserved encoding
    run_op(OP_XOR, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 0, 1'b0, '0, '0, '0);
    chk("xor_mode", 64'(lo_mode), 64'(OP_XOR));
    run_op(OP_NOT, 64'd0, 64'hDEADBEEF_01234567, 0, 1'b0, '0, '0, '0);
    chk("not_mode", 64'(hi_mode), 64'(OP_NOT));
    run_op(3'b110, 64'hAAAA5555_12345678, 64'h0F0F0F0F_F0F0F0F0, 0, 1'b0, '0, '0, '0);
    chk("rsvd_lo_ab", {lo_a, lo_b}, 64'd0);
    chk("rsvd_hi_ab", {hi_a, hi_b}, 64'd0);

    // Backpressure, then a request queued alongside rsp_ready
    run_op(OP_ADD, 64'h01234567_89ABCDEF, 64'h11111111_11111111, 5, 1'b1,
           OP_OR, 64'hF0000000_0000000F, 64'h0000FFFF_FFFF0000);
    run_op(OP_OR, 64'hF0000000_0000000F, 64'h0000FFFF_FFFF0000, 1, 1'b0, '0, '0, '0);
    chk("queued_wait", 64'(acc_wait), 64'd0);
    chk("queued_lat", 64'(lat), 64'd3);

    // Random mix including reserved encodings
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = {$urandom, $urandom};
      rb  = (i == 3) ? ra : {$urandom, $urandom};
      run_op(rop, ra, rb, int'($urandom_range(0, 2)), 1'b0, '0, '0, '0);
    end

    // Nonzero held result before the reset test
    run_op(OP_ADD, 64'h00000010_00000000, 64'h00000000_00000020, 0, 1'b0, '0, '0, '0);

    // Reset during HI of an ADD: immediate reset values, no response
    bus.req_valid = 1'b1;
    bus.req_op    = OP_ADD;
    bus.req_a     = 64'h00000001_FFFFFFFF;
    bus.req_b     = 64'd1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("hi_before_rst_cin", 64'(alu_cin), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 64'(bus.rsp_valid), 64'd0);
    end

    run_op(OP_ADD, 64'd2, 64'd3, 0, 1'b0, '0, '0, '0);
    chk("post_rst_lat", 64'(lat), 64'd3);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
